// File: rtl/deser_pkg.sv
// Shared types for the deser32 serial-to-parallel receiver.
package deser_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef logic [4:0] bit_idx_t;

    typedef enum logic {
        COLLECT,
        HOLD
    } deser_state_t;

endpackage

// File: rtl/decoder5to32.sv
// One-hot write-enable decoder; the receive-side counterpart of a mux32 select.
module decoder5to32
    import deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [WIDTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/deser32.sv
// Steers one serial bit per accepted beat into bit[fill_count] of a word and
// presents each completed word on a valid/ready output port.
module deser32
    import deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] fill_count
);

    deser_state_t     state;
    deser_state_t     state_next;
    logic [WIDTH-1:0] assembly;
    logic [WIDTH-1:0] bit_we;
    logic             final_bit;
    logic             accept;
    logic             last_accept;

    // Only the last bit of a word can stall: it needs the output register free.
    assign final_bit   = (fill_count == IDX_W'(WIDTH - 1));
    assign in_ready    = !(final_bit && out_valid && !out_ready);
    assign accept      = in_valid && in_ready && !clear;
    assign last_accept = accept && final_bit;
    assign out_valid   = (state == HOLD);

    decoder5to32 #(
        .WIDTH (WIDTH)
    ) u_decoder (
        .idx    (fill_count),
        .en     (accept),
        .onehot (bit_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assembly <= '0;
        end else begin
            assembly <= (assembly & ~bit_we) | ({WIDTH{in_bit}} & bit_we);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count <= '0;
        end else if (clear) begin
            fill_count <= '0;
        end else if (accept) begin
            fill_count <= fill_count + IDX_W'(1);
        end
    end

    // The final bit bypasses the assembly register straight into the output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word <= '0;
        end else if (last_accept) begin
            out_word <= {in_bit, assembly[WIDTH-2:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (last_accept) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready && !last_accept) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_deser32.sv
// Scoreboard bench for deser32: words are queued as they are sent and a
// monitor pops and compares each one the DUT hands over.
module tb_deser32;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fill_count;

    logic [31:0] expq[$];
    int          vectors;
    int          miscompares;

    deser32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Holds in_valid until the bit is taken; returns 1 time unit after that edge.
    task automatic sendBit(input logic b);
        int   waitCycles;
        logic took;
        waitCycles = 0;
        took       = 1'b0;
        in_valid   = 1'b1;
        in_bit     = b;
        while (!took && waitCycles < 100) begin
            @(negedge clk);
            took = in_ready && !clear;
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (!took) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL bit accept timeout: in_ready got %b, expected 1", in_ready);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        expq.push_back(word);
        for (int i = 0; i < 32; i++) begin
            sendBit(word[i]);
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected word: got %h, expected none", out_word);
            end else begin
                logic [31:0] exp;
                exp = expq.pop_front();
                if (out_word !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL out_word: got %h, expected %h", out_word, exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w2;
        vectors     = 0;
        miscompares = 0;

        // Reset with junk on the inputs
        rst_n     = 1'b0;
        clear     = 1'($urandom);
        in_bit    = 1'($urandom);
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_word", out_word, 32'd0);
        checkOutput("reset fill_count", 32'(fill_count), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        clear = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-release out_valid", 32'(out_valid), 32'd0);
        checkOutput("post-release out_word", out_word, 32'd0);
        checkOutput("post-release fill_count", 32'(fill_count), 32'd0);
        checkOutput("post-release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Alternating bits
        out_ready = 1'b1;
        applyStimulus(32'hAAAA_AAAA);
        checkOutput("alt out_valid after bit31", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        checkOutput("alt out_valid one cycle", 32'(out_valid), 32'd0);

        // Walking one across every decoder output
        for (int k = 0; k < 32; k++) begin
            applyStimulus(32'h1 << k);
        end
        repeat (2) @(posedge clk); #1;

        // Back-pressure on the final bit
        out_ready = 1'b0;
        w2 = 32'h1234_5678;
        applyStimulus(32'hA5A5_F00D);
        expq.push_back(w2);
        for (int i = 0; i < 31; i++) begin
            sendBit(w2[i]);
        end
        in_valid = 1'b1;
        in_bit   = w2[31];
        @(negedge clk);
        checkOutput("bp fill_count", 32'(fill_count), 32'd31);
        checkOutput("bp in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp out_word held", out_word, 32'hA5A5_F00D);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bp out_word stable", out_word, 32'hA5A5_F00D);
        checkOutput("bp in_ready stable", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp no bubble out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp next word loaded", out_word, w2);
        @(posedge clk); #1;
        checkOutput("bp out_valid drops", 32'(out_valid), 32'd0);

        // Streaming two words back to back
        applyStimulus(32'hDEAD_BEEF);
        checkOutput("stream word0 valid", 32'(out_valid), 32'd1);
        applyStimulus(32'hCAFE_F00D);
        checkOutput("stream word1 valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // Clear mid-word drops the partial word and the same-cycle bit
        for (int i = 0; i < 10; i++) begin
            sendBit(1'b1);
        end
        checkOutput("clear pre fill_count", 32'(fill_count), 32'd10);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clear fill_count", 32'(fill_count), 32'd0);
        applyStimulus(32'h0F0F_3C3C);
        @(posedge clk); #1;

        // Asynchronous reset while a word is held and another is partly built
        out_ready = 1'b0;
        applyStimulus(32'h1111_2222);
        for (int i = 0; i < 17; i++) begin
            sendBit(1'($urandom));
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid fill_count", 32'(fill_count), 32'd17);
        checkOutput("mid out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async out_valid", 32'(out_valid), 32'd0);
        checkOutput("async out_word", out_word, 32'd0);
        checkOutput("async fill_count", 32'(fill_count), 32'd0);
        checkOutput("async in_ready", 32'(in_ready), 32'd1);
        void'(expq.pop_back());
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(32'h8000_0001);
        repeat (3) @(posedge clk); #1;

        checkOutput("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
